// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset pulse, lock wait/hold and core reset release sequencer
module pll_reset_seq #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int HOLD_CYCLES    = 1024
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       soft_reset_req,
   output logic       pll_rst,
   output logic       reset_out,
   output logic       ready,
   output logic       lock_lost,
   output logic [7:0] retry_count,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   // Terminal counts: the counter runs 0..N-1 so each state lasts exactly N cycles
   // and the 16-bit counter can never wrap, even at LOCK_TIMEOUT = 65535.
   localparam logic [15:0] PLL_RST_LAST = 16'(PLL_RST_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);

   state_t      state;
   state_t      state_n;
   logic [15:0] cnt;
   logic [15:0] cnt_n;
   logic        timeout_hit;
   logic        lost_hit;
   logic        sync_meta;
   logic        locked_s;

   // Two-flop synchronizer: pll_locked comes from the PLL, asynchronous to clk_50.
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         sync_meta <= pll_locked;
         locked_s  <= sync_meta;
      end
   end

   // Next-state and counter logic; lock loss is checked before soft reset in RUN.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      timeout_hit = 1'b0;
      lost_hit    = 1'b0;
      case (state)
         ST_PLL_RST: begin
            if (cnt >= PLL_RST_LAST) begin
               state_n = ST_WAIT_LOCK;
               cnt_n   = 16'd0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_n = ST_STABLE;
               cnt_n   = 16'd0;
            end else if (cnt >= TIMEOUT_LAST) begin
               state_n     = ST_PLL_RST;
               cnt_n       = 16'd0;
               timeout_hit = 1'b1;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_n = ST_WAIT_LOCK;
               cnt_n   = 16'd0;
            end else if (cnt >= HOLD_LAST) begin
               state_n = ST_RUN;
               cnt_n   = 16'd0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_n  = ST_PLL_RST;
               cnt_n    = 16'd0;
               lost_hit = 1'b1;
            end else if (soft_reset_req) begin
               state_n = ST_STABLE;
               cnt_n   = 16'd0;
            end
         end
         default: begin
            state_n = ST_PLL_RST;
            cnt_n   = 16'd0;
         end
      endcase
   end

   // State, counter and outputs; outputs are decoded from the next state so they
   // change on the same edge as the state and are all flop outputs.
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         state       <= ST_PLL_RST;
         cnt         <= 16'd0;
         pll_rst     <= 1'b1;
         reset_out   <= 1'b1;
         ready       <= 1'b0;
         lock_lost   <= 1'b0;
         retry_count <= 8'd0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pll_rst   <= (state_n == ST_PLL_RST);
         reset_out <= (state_n != ST_RUN);
         ready     <= (state_n == ST_RUN);
         lock_lost <= lost_hit;
         if (timeout_hit && (retry_count != 8'hFF)) begin
            retry_count <= retry_count + 8'd1;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - self-checking bench for pll_reset_seq with a cycle-level reference model
module tb_pll_reset_seq;

   localparam int PRC = 4;
   localparam int LTO = 20;
   localparam int HLD = 8;

   logic       clk_50 = 1'b0;
   logic       reset = 1'b1;
   logic       pll_locked = 1'b0;
   logic       soft_reset_req = 1'b0;
   logic       pll_rst;
   logic       reset_out;
   logic       ready;
   logic       lock_lost;
   logic [7:0] retry_count;
   logic [1:0] state_dbg;

   pll_reset_seq #(
      .PLL_RST_CYCLES(PRC),
      .LOCK_TIMEOUT  (LTO),
      .HOLD_CYCLES   (HLD)
   ) dut (
      .clk_50        (clk_50),
      .reset         (reset),
      .pll_locked    (pll_locked),
      .soft_reset_req(soft_reset_req),
      .pll_rst       (pll_rst),
      .reset_out     (reset_out),
      .ready         (ready),
      .lock_lost     (lock_lost),
      .retry_count   (retry_count),
      .state_dbg     (state_dbg)
   );

   always #10 clk_50 = ~clk_50;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase 0..3 = reset pulse, waiting, holding, running.
   // elapsed counts cycles spent in the current phase; lock history is a two-deep delay line.
   int m_phase;
   int m_elapsed;
   int m_retry;
   int m_lost;
   int m_hist1;
   int m_hist2;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase   = 0;
      m_elapsed = 0;
      m_retry   = 0;
      m_lost    = 0;
      m_hist1   = 0;
      m_hist2   = 0;
   endtask

   task automatic enter(input int p);
      m_phase   = p;
      m_elapsed = 0;
   endtask

   task automatic model_step();
      int seen;
      if (reset) begin
         model_reset();
         return;
      end
      seen   = m_hist2;
      m_lost = 0;
      m_elapsed++;
      if (m_phase == 0) begin
         if (m_elapsed == PRC) enter(1);
      end else if (m_phase == 1) begin
         if (seen == 1) enter(2);
         else if (m_elapsed == LTO) begin
            enter(0);
            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
         end
      end else if (m_phase == 2) begin
         if (seen == 0) enter(1);
         else if (m_elapsed == HLD) enter(3);
      end else begin
         if (seen == 0) begin
            enter(0);
            m_lost = 1;
         end else if (soft_reset_req) enter(2);
      end
      m_hist2 = m_hist1;
      m_hist1 = pll_locked ? 1 : 0;
   endtask

   task automatic check_all();
      check_val("state_dbg",   int'(state_dbg),   m_phase);
      check_val("pll_rst",     int'(pll_rst),     (m_phase == 0) ? 1 : 0);
      check_val("reset_out",   int'(reset_out),   (m_phase != 3) ? 1 : 0);
      check_val("ready",       int'(ready),       (m_phase == 3) ? 1 : 0);
      check_val("lock_lost",   int'(lock_lost),   m_lost);
      check_val("retry_count", int'(retry_count), m_retry);
   endtask

   // One clock: model advances on the edge, DUT is compared on the falling edge.
   task automatic cycle();
      @(posedge clk_50);
      model_step();
      @(negedge clk_50);
      check_all();
   endtask

   task automatic wait_state(input string tag, input int st, input int bound);
      int n = 0;
      while (int'(state_dbg) != st && n < bound) begin
         cycle();
         n++;
      end
      check_val(tag, int'(state_dbg), st);
   endtask

   initial begin
      int n;
      int w;
      int saw_wait;
      int ro_ok;
      int pll_ok;
      int hold_left;

      model_reset();
      // Reset held: all outputs at their reset values.
      repeat (3) cycle();
      check_val("rst_state", int'(state_dbg), 0);
      check_val("rst_pll_rst", int'(pll_rst), 1);

      // Nominal start.
      reset = 1'b0;
      w = 1;
      cycle();
      while (pll_rst && w < 50) begin
         w++;
         cycle();
      end
      check_val("nom_pll_rst_width", w, PRC);
      repeat (10 - PRC) cycle();
      pll_locked = 1'b1;
      n = 0;
      do begin
         cycle();
         n++;
      end while (reset_out && n < 100);
      check_val("nom_release_latency", n, 2 + 1 + HLD);
      check_val("nom_ready", int'(ready), 1);
      check_val("nom_retry", int'(retry_count), 0);

      // Soft reset from RUN.
      soft_reset_req = 1'b1;
      cycle();
      soft_reset_req = 1'b0;
      check_val("soft_reset_out_rise", int'(reset_out), 1);
      n = 1;
      pll_ok = 1;
      while (reset_out && n < 100) begin
         cycle();
         n++;
         if (pll_rst) pll_ok = 0;
      end
      check_val("soft_latency", n, HLD + 1);
      check_val("soft_pll_rst_low", pll_ok, 1);

      // Soft reset together with lock loss: lock loss wins.
      pll_locked = 1'b0;
      cycle();
      cycle();
      soft_reset_req = 1'b1;
      cycle();
      soft_reset_req = 1'b0;
      check_val("prio_state", int'(state_dbg), 0);
      check_val("prio_pll_rst", int'(pll_rst), 1);
      check_val("prio_lock_lost", int'(lock_lost), 1);

      // Glitch while holding lock.
      pll_locked = 1'b1;
      wait_state("glitch_reach_stable", 2, 80);
      repeat (4) cycle();
      pll_locked = 1'b0;
      saw_wait = 0;
      ro_ok = 1;
      repeat (3) begin
         cycle();
         if (state_dbg == 2'd1) saw_wait = 1;
         if (!reset_out) ro_ok = 0;
      end
      pll_locked = 1'b1;
      n = 0;
      do begin
         cycle();
         n++;
         if (state_dbg == 2'd1) saw_wait = 1;
      end while (reset_out && n < 100);
      check_val("glitch_saw_wait", saw_wait, 1);
      check_val("glitch_reset_held", ro_ok, 1);
      check_val("glitch_hold_restart", n, 2 + 1 + HLD);
      check_val("glitch_retry", int'(retry_count), 0);

      // Lock loss in RUN.
      pll_locked = 1'b0;
      n = 0;
      do begin
         cycle();
         n++;
      end while (state_dbg != 2'd0 && n < 20);
      check_val("loss_latency", n, 3);
      check_val("loss_lock_lost", int'(lock_lost), 1);
      check_val("loss_reset_out", int'(reset_out), 1);
      check_val("loss_ready", int'(ready), 0);
      w = 1;
      cycle();
      check_val("loss_pulse_single", int'(lock_lost), 0);
      while (pll_rst && w < 50) begin
         w++;
         cycle();
      end
      check_val("loss_pll_rst_width", w, PRC);

      // Asynchronous reset while running.
      pll_locked = 1'b1;
      wait_state("reach_run", 3, 200);
      @(posedge clk_50);
      #5;
      reset = 1'b1;
      #1;
      check_val("async_state", int'(state_dbg), 0);
      check_val("async_pll_rst", int'(pll_rst), 1);
      check_val("async_reset_out", int'(reset_out), 1);
      check_val("async_ready", int'(ready), 0);
      check_val("async_retry", int'(retry_count), 0);
      model_reset();
      @(negedge clk_50);
      check_all();
      pll_locked = 1'b0;
      cycle();

      // Lock timeout and retry saturation.
      reset = 1'b0;
      n = 0;
      while (retry_count == 8'd0 && n < 100) begin
         cycle();
         n++;
      end
      check_val("timeout_first", n, PRC + LTO);
      w = 1;
      cycle();
      while (pll_rst && w < 50) begin
         w++;
         cycle();
      end
      check_val("timeout_pll_rst_width", w, PRC);
      n = w;
      while (retry_count == 8'd1 && n < 100) begin
         cycle();
         n++;
      end
      check_val("timeout_period", n, PRC + LTO);
      repeat (300 * (PRC + LTO)) cycle();
      check_val("retry_saturate", int'(retry_count), 255);

      // Randomized lock activity, soft requests and occasional resets.
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      hold_left = 0;
      repeat (4000) begin
         if (hold_left == 0) begin
            pll_locked = ($urandom_range(0, 99) < 75);
            hold_left  = $urandom_range(1, 40);
         end
         hold_left--;
         soft_reset_req = ($urandom_range(0, 11) == 0);
         reset = ($urandom_range(0, 599) == 0);
         cycle();
      end
      reset = 1'b0;
      soft_reset_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
